// File: rtl/m_dmem_access_ctrl.sv
// m_dmem_access_ctrl
// Sequences MEM-stage loads/stores into a req/ready handshake with an
// external data memory. Freezes the upstream pipeline while an access is
// outstanding, returns load data with a one-cycle write-back strobe and
// raises a sticky flag if the memory fails to answer in time.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   memreadM, memwriteM     load / store intent of the MEM-stage instruction
//   aluoutM, writedataM     effective address and store data
//   mem_req, mem_we         registered request and write enable to memory
//   mem_addr, mem_wdata     registered address and store data to memory
//   mem_ready, mem_rdata    memory completion and load data
//   stall                   combinational freeze of IF/ID/EX/MEM registers
//   readdata, wb_valid      registered load data and completion strobe
//   err_timeout             sticky timeout flag, cleared only by reset
//
// state | meaning
// IDLE  | no access outstanding; accept the MEM-stage access if present
// WAIT  | request issued; waiting for mem_ready or timeout
// DONE  | access finished; pipeline advances, MEM/WB captures readdata

module m_dmem_access_ctrl #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] readdata,
    output logic        wb_valid,
    output logic        err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          access;
    logic          accept;
    logic          ready_hit;
    logic          tc_hit;

    assign access    = memreadM | memwriteM;
    assign accept    = (state == IDLE) && access;
    assign ready_hit = (state == WAIT) && mem_ready;
    // ready takes priority over the terminal count on the last WAIT cycle
    assign tc_hit    = (state == WAIT) && !mem_ready && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (access) state_nx = WAIT;
            WAIT:    if (mem_ready || (cnt == '0)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = access;
            WAIT:    stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Down-counter loaded on request issue; terminal count 0 marks the
    // TIMEOUT-th WAIT cycle without ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if ((state == WAIT) && !mem_ready && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            readdata    <= '0;
            wb_valid    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wb_valid <= ready_hit | tc_hit;
            if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= memwriteM;
                mem_addr  <= aluoutM;
                mem_wdata <= writedataM;
            end
            if (ready_hit) begin
                mem_req <= 1'b0;
                if (!mem_we) readdata <= mem_rdata;
            end
            if (tc_hit) begin
                mem_req     <= 1'b0;
                err_timeout <= 1'b1;
                if (!mem_we) readdata <= ERR_DATA;
            end
        end
    end

endmodule
